// File: rtl/tc_clk_int_div.sv
// Runtime-programmable integer clock divider with glitch-free divisor changes.
// Drives a downstream 2:1 clock mux: I0=div_clk_o, I1=clk_i, S=bypass_o.
module tc_clk_int_div #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             div_clk_o,
  output logic             bypass_o
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO    = '0;

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] pend_q, pend_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic             clk_n, byp_n, ready_n;

  logic [DIV_W-1:0] d, half, cnt_step, pend_d, pend_half;
  logic             d_one, bnd, xfer, stop;

  // Effective divisors (0 behaves as 1) and period boundary.
  always_comb begin
    d         = (div_q == ZERO) ? ONE : div_q;
    half      = d >> 1;
    d_one     = (d == ONE);
    bnd       = (cnt_q == (d - ONE));
    cnt_step  = bnd ? ZERO : (cnt_q + ONE);
    pend_d    = (pend_q == ZERO) ? ONE : pend_q;
    pend_half = pend_d >> 1;
    xfer      = div_valid_i && div_ready_o;
    stop      = !en_i && (d_one || bnd);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    pend_n  = pend_q;
    cnt_n   = cnt_q;
    clk_n   = div_clk_o;
    byp_n   = bypass_o;

    case (state_q)
      IDLE: begin
        cnt_n = ZERO;
        clk_n = 1'b0;
        byp_n = 1'b0;
        if (xfer) begin
          div_n = div_i;
        end else if (en_i) begin
          state_n = RUN;
          clk_n   = (half != ZERO);
          byp_n   = d_one;
        end
      end

      RUN: begin
        if (stop) begin
          // Period complete and disabled; a same-cycle request just loads the divisor.
          state_n = IDLE;
          cnt_n   = ZERO;
          clk_n   = 1'b0;
          byp_n   = 1'b0;
          if (xfer) div_n = div_i;
        end else begin
          if (xfer) begin
            pend_n  = div_i;
            state_n = PENDING;
          end
          if (d_one) begin
            cnt_n = ZERO;
            clk_n = 1'b0;
            byp_n = 1'b1;
          end else begin
            cnt_n = cnt_step;
            clk_n = (cnt_step < half);
            byp_n = 1'b0;
          end
        end
      end

      PENDING: begin
        if (d_one || bnd) begin
          div_n = pend_q;
          cnt_n = ZERO;
          if (en_i) begin
            state_n = RUN;
            clk_n   = (pend_half != ZERO);
            byp_n   = (pend_d == ONE);
          end else begin
            state_n = IDLE;
            clk_n   = 1'b0;
            byp_n   = 1'b0;
          end
        end else begin
          cnt_n = cnt_step;
          clk_n = (cnt_step < half);
          byp_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = ZERO;
        clk_n   = 1'b0;
        byp_n   = 1'b0;
      end
    endcase

    ready_n = (state_n != PENDING);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      div_q       <= DEF_DIV;
      pend_q      <= DEF_DIV;
      cnt_q       <= ZERO;
      div_clk_o   <= 1'b0;
      bypass_o    <= 1'b0;
      div_ready_o <= 1'b1;
    end else begin
      state_q     <= state_n;
      div_q       <= div_n;
      pend_q      <= pend_n;
      cnt_q       <= cnt_n;
      div_clk_o   <= clk_n;
      bypass_o    <= byp_n;
      div_ready_o <= ready_n;
    end
  end

endmodule

// File: tb/tb_tc_clk_int_div.sv
// Directed self-checking bench for tc_clk_int_div (DIV_W=8, DEFAULT_DIV=1).
module tb_tc_clk_int_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div;
  logic       div_valid;
  logic       div_ready;
  logic       div_clk;
  logic       bypass;

  int n_checks = 0;
  int n_errors = 0;

  tc_clk_int_div #(.DIV_W(8), .DEFAULT_DIV(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
    .div_clk_o  (div_clk),
    .bypass_o   (bypass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input logic [7:0] v);
    div = v; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
  endtask

  // Step n cycles checking div_clk against pattern bits (LSB first) and bypass low.
  task automatic run_pat(input string tag, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s clk[%0d]", tag, i), int'(div_clk), int'(pat[i]));
      check($sformatf("%s byp[%0d]", tag, i), int'(bypass), 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0; div_valid = 1'b0;
    #22;
    check("rst clk", int'(div_clk), 0);
    check("rst byp", int'(bypass), 0);
    check("rst rdy", int'(div_ready), 1);
    rst = 1'b0;

    // Default divisor 1: bypass one cycle after enable.
    en = 1'b1;
    step();
    check("d1 byp", int'(bypass), 1);
    check("d1 clk", int'(div_clk), 0);
    en = 1'b0;
    step();
    check("d1 off byp", int'(bypass), 0);

    // d=4: 1,1,0,0 repeating.
    load_div(8'd4);
    en = 1'b1;
    run_pat("d4", 8, 16'b0011_0011);
    en = 1'b0;
    step();
    check("d4 idle clk", int'(div_clk), 0);

    // d=5: 1,1,0,0,0 repeating.
    load_div(8'd5);
    en = 1'b1;
    run_pat("d5", 10, 16'b00011_00011);
    en = 1'b0;
    step();
    check("d5 idle clk", int'(div_clk), 0);

    // d=4 -> 2 requested mid-period.
    load_div(8'd4);
    en = 1'b1;
    run_pat("d4b", 2, 16'b11);
    div = 8'd2; div_valid = 1'b1;
    step();
    check("p42 rdy0", int'(div_ready), 0);
    check("p42 clk0", int'(div_clk), 0);
    div = 8'd7;
    step();
    check("p42 rdy1", int'(div_ready), 0);
    check("p42 clk1", int'(div_clk), 0);
    div_valid = 1'b0;
    step();
    check("p42 apply clk", int'(div_clk), 1);
    check("p42 apply rdy", int'(div_ready), 1);
    run_pat("d2", 3, 16'b010);
    en = 1'b0;
    step();
    check("d2 idle clk", int'(div_clk), 0);

    // d=3 -> 1 requested at a boundary cycle.
    load_div(8'd3);
    en = 1'b1;
    run_pat("d3", 3, 16'b001);
    div = 8'd1; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("p31 clk", int'(div_clk), 1);
    check("p31 rdy", int'(div_ready), 0);
    check("p31 byp", int'(bypass), 0);
    run_pat("p31 tail", 2, 16'b00);
    step();
    check("p31 byp rise", int'(bypass), 1);
    check("p31 clk low", int'(div_clk), 0);
    check("p31 rdy back", int'(div_ready), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("byp hold", int'(bypass), 1);
      check("byp clk0", int'(div_clk), 0);
    end
    en = 1'b0;
    step();
    check("byp off", int'(bypass), 0);

    // d=6, enable dropped at cnt=1: period completes, no runt.
    load_div(8'd6);
    en = 1'b1;
    run_pat("d6", 2, 16'b11);
    en = 1'b0;
    run_pat("d6 drain", 7, 16'b000_0001);

    // Async reset while PENDING at d=8 discards the pending divisor.
    load_div(8'd8);
    en = 1'b1;
    run_pat("d8", 2, 16'b11);
    div = 8'd3; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("p8 rdy", int'(div_ready), 0);
    check("p8 clk", int'(div_clk), 1);
    #1 rst = 1'b1;
    #1;
    check("arst clk", int'(div_clk), 0);
    check("arst byp", int'(bypass), 0);
    check("arst rdy", int'(div_ready), 1);
    #1 rst = 1'b0;
    step();
    check("post rst byp", int'(bypass), 1);
    check("post rst clk", int'(div_clk), 0);
    step();
    check("post rst byp2", int'(bypass), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
